pkt_fifo: RTL

//  Parametrised packet-aware FIFO for USB non-data (token/handshake/setup) and data bytes.

---
 rtl/usb_fifo_pkg.sv | 13 +
 rtl/pkt_fifo_ram.sv | 24 ++
 rtl/pkt_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/usb_fifo_pkg.sv
// Shared types and constants for the USB packet FIFO.
// Consumers: pkt_fifo, pkt_fifo_ram and the pkt_fifo testbench.
package usb_fifo_pkg;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_ACCUM,
      PF_DROP
   } pf_state_t;

   localparam int PF_STAT_W = 16;

endpackage

// File: rtl/pkt_fifo_ram.sv
// Packet FIFO storage: DEPTH x DW, one synchronous write port, one asynchronous read port.
// The array is deliberately left without reset; validity is tracked by the pointers.
module pkt_fifo_ram #(
   parameter int DEPTH = 50,
   parameter int DW    = 9,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet-aware FIFO: words become readable only once their packet is committed with w_eop;
// abort or overflow rolls back the open packet. Define PKT_FIFO_STATS_EN for drop_cnt/ovf_cnt.
module pkt_fifo
   import usb_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 50,
   parameter int AF_THRESH = 40
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_enable,
   input  logic [WIDTH-1:0]           w_data,
   input  logic                       w_eop,
   input  logic                       w_abort,
   input  logic                       r_enable,
   output logic [WIDTH-1:0]           r_data,
   output logic                       r_eop,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] pkt_count,
   output pf_state_t                  dbg_state,
   output logic                       drop
`ifdef PKT_FIFO_STATS_EN
   ,
   output logic [PF_STAT_W-1:0]       drop_cnt,
   output logic [PF_STAT_W-1:0]       ovf_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   // Handshake: a write is taken on a rising edge when w_enable is high, w_abort is low,
   // full is low and the FSM is not in DROP; a read is taken when r_enable is high and
   // empty is low. r_data/r_eop are show-ahead and valid whenever empty is low.

   pf_state_t     state, state_nx;
   logic [AW-1:0] wr_ptr, cm_ptr, rd_ptr;
   logic [AW-1:0] wr_ptr_inc, rd_ptr_inc;
   logic [CW-1:0] cnt_c, cnt_p, pkt_cnt, occ;
   logic [WIDTH:0] rd_word;
   logic          wr_ok, commit, ovf, rd_ok, rd_eop, rollback, drop_set;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_ptr_inc = ptr_inc(wr_ptr);
   assign rd_ptr_inc = ptr_inc(rd_ptr);

   // Flags come from registered occupancy only, so a same-cycle read never admits a write.
   assign occ         = cnt_c + cnt_p;
   assign full        = (occ == CW'(DEPTH));
   assign almost_full = (occ >= CW'(AF_THRESH));
   assign empty       = (cnt_c == '0);

   assign wr_ok    = w_enable & ~w_abort & ~full & (state != PF_DROP);
   assign commit   = wr_ok & w_eop;
   assign ovf      = w_enable & ~w_abort & full & (state != PF_DROP);
   assign rd_ok    = r_enable & ~empty;
   assign rd_eop   = rd_word[WIDTH];
   assign rollback = w_abort | ovf;
   assign drop_set = (w_abort & ((cnt_p != '0) | (state == PF_DROP))) | ovf;

   pkt_fifo_ram #(
      .DEPTH (DEPTH),
      .DW    (WIDTH + 1),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata ({w_eop, w_data}),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   assign r_data    = empty ? '0 : rd_word[WIDTH-1:0];
   assign r_eop     = ~empty & rd_eop;
   assign count     = cnt_c;
   assign pkt_count = pkt_cnt;
   assign dbg_state = state;

   always_comb begin
      state_nx = state;
      case (state)
         PF_IDLE: begin
            if (ovf)                 state_nx = PF_DROP;
            else if (wr_ok & ~w_eop) state_nx = PF_ACCUM;
         end
         PF_ACCUM: begin
            if (ovf)                     state_nx = PF_DROP;
            else if (w_abort | commit)   state_nx = PF_IDLE;
         end
         PF_DROP: begin
            if (w_abort | (w_enable & w_eop)) state_nx = PF_IDLE;
         end
         default: state_nx = PF_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= PF_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         cm_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_c   <= '0;
         cnt_p   <= '0;
         pkt_cnt <= '0;
         drop    <= 1'b0;
      end else begin
         drop <= drop_set;
         if (rollback) begin
            wr_ptr <= cm_ptr;
            cnt_p  <= '0;
         end else if (wr_ok) begin
            wr_ptr <= wr_ptr_inc;
            if (commit) begin
               cm_ptr <= wr_ptr_inc;
               cnt_p  <= '0;
            end else begin
               cnt_p <= cnt_p + 1'b1;
            end
         end
         if (rd_ok) rd_ptr <= rd_ptr_inc;
         // Commit publishes the whole open packet (pending words plus this one) at once.
         cnt_c   <= cnt_c + (commit ? cnt_p + 1'b1 : '0) - CW'(rd_ok);
         pkt_cnt <= pkt_cnt + CW'(commit) - CW'(rd_ok & rd_eop);
      end
   end

`ifdef PKT_FIFO_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
         ovf_cnt  <= '0;
      end else begin
         if (drop_set && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
         if (w_enable && !w_abort && (full || state == PF_DROP) && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
      end
   end
`endif

endmodule
